// File: rtl/psum_accum_col.sv
// Column-bottom partial-sum accumulator: buffers one tile pass of psums,
// accumulates across K-tiles with signed saturation, then drains over valid/ready.
module psum_accum_col #(
  parameter int PSUM_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [PSUM_WIDTH-1:0] psum_i,
  input  logic                         psum_en_i,
  input  logic                         tile_start_i,
  input  logic                         first_tile_i,
  input  logic                         last_tile_i,
  output logic signed [ACC_WIDTH-1:0]  acc_o,
  output logic                         acc_valid_o,
  input  logic                         acc_ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        first_q, last_q;
  logic signed [ACC_WIDTH-1:0] mem [DEPTH];
  logic signed [ACC_WIDTH-1:0] psum_x, acc_sat;
  logic        [ACC_WIDTH:0]   acc_sum;
  logic                        wr_en, last_wr, beat, last_beat;

  assign psum_x    = ACC_WIDTH'(psum_i);
  assign wr_en     = (state == ACCUM) && psum_en_i;
  assign last_wr   = wr_en && (wr_ptr == LAST_IDX);
  assign beat      = (state == DRAIN) && acc_valid_o && acc_ready_i;
  assign last_beat = beat && (rd_ptr == LAST_IDX);
  assign busy_o    = (state != IDLE);

  // One guard bit: a mismatch between the top two sum bits means overflow.
  always_comb begin
    acc_sum = {mem[wr_ptr][ACC_WIDTH-1], mem[wr_ptr]} + {psum_x[ACC_WIDTH-1], psum_x};
    acc_sat = acc_sum[ACC_WIDTH-1:0];
    if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1])
      acc_sat = acc_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tile_start_i) state_nxt = ACCUM;
      ACCUM:   if (last_wr)      state_nxt = last_q ? DRAIN : IDLE;
      DRAIN:   if (last_beat)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // Buffer is deliberately left unreset; first_tile_i overwrites it.
  always_ff @(posedge clk) begin
    if (!rst_n && wr_en) mem[wr_ptr] <= first_q ? psum_x : acc_sat;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      acc_o       <= '0;
      acc_valid_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (tile_start_i) begin
            wr_ptr  <= '0;
            first_q <= first_tile_i;
            last_q  <= last_tile_i;
          end
          if (psum_en_i) err_o <= 1'b1;
        end
        ACCUM: begin
          if (tile_start_i) err_o <= 1'b1;
          if (wr_en) wr_ptr <= wr_ptr + AW'(1);
          // Entry 0 was written on an earlier cycle, so it is safe to present now.
          if (last_wr && last_q) begin
            rd_ptr      <= '0;
            acc_o       <= mem[0];
            acc_valid_o <= 1'b1;
          end
        end
        DRAIN: begin
          if (tile_start_i || psum_en_i) err_o <= 1'b1;
          if (last_beat) begin
            rd_ptr      <= '0;
            acc_valid_o <= 1'b0;
            done_o      <= 1'b1;
          end else if (beat) begin
            rd_ptr <= rd_ptr + AW'(1);
            acc_o  <= mem[rd_ptr + AW'(1)];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_accum_col.sv
// Directed bench for psum_accum_col: arithmetic model of the buffer plus an
// expected-drain queue, checked every cycle on the falling edge.
module tb_psum_accum_col;
  localparam int PW = 32, AWD = 32, D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n = 1'b1;
  logic signed [PW-1:0]  psum_i = '0;
  logic                  psum_en_i = 1'b0, tile_start_i = 1'b0;
  logic                  first_tile_i = 1'b0, last_tile_i = 1'b0;
  logic signed [AWD-1:0] acc_o;
  logic                  acc_valid_o, acc_ready_i = 1'b0;
  logic                  busy_o, done_o, err_o;

  psum_accum_col #(.PSUM_WIDTH(PW), .ACC_WIDTH(AWD), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .psum_i(psum_i), .psum_en_i(psum_en_i),
    .tile_start_i(tile_start_i), .first_tile_i(first_tile_i), .last_tile_i(last_tile_i),
    .acc_o(acc_o), .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int     checks = 0, failures = 0;
  longint model_mem [D];
  longint exp_q [$];
  longint v [D];
  bit     exp_err = 1'b0, done_exp = 1'b0, cmp_en = 1'b0;

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint x);
    if (x > 64'sh7FFF_FFFF)   return 64'sh7FFF_FFFF;
    if (x < -64'sh8000_0000)  return -64'sh8000_0000;
    return x;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Feeds one tile pass; bad_at >= 0 also pulses tile_start_i on that psum.
  task automatic run_tile(input bit first, input bit last, input longint p [D],
                          input int gap, input int bad_at);
    tile_start_i = 1'b1; first_tile_i = first; last_tile_i = last;
    cyc();
    tile_start_i = 1'b0; first_tile_i = 1'b0; last_tile_i = 1'b0;
    check("busy_accum", busy_o, 1);
    for (int i = 0; i < D; i++) begin
      psum_i = p[i][PW-1:0];
      psum_en_i = 1'b1;
      if (i == bad_at) tile_start_i = 1'b1;
      cyc();
      if (i == bad_at) exp_err = 1'b1;
      model_mem[i] = first ? p[i] : sat(model_mem[i] + p[i]);
      if (last && i == D-1)
        for (int j = 0; j < D; j++) exp_q.push_back(model_mem[j]);
      psum_en_i = 1'b0; tile_start_i = 1'b0;
      if (i != D-1) repeat (gap) cyc();
    end
  endtask

  task automatic drain(input logic [15:0] pat, input int n);
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      acc_ready_i = (k < n) ? pat[k] : 1'b1;
      cyc();
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    acc_ready_i = 1'b0;
    cyc(); cyc();
    check("busy_after_drain", busy_o, 0);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("done", done_o, done_exp);
      done_exp = 1'b0;
      check("err", err_o, exp_err);
      check("valid", acc_valid_o, exp_q.size() != 0);
      if (acc_valid_o && exp_q.size() != 0) begin
        check("acc", acc_o, exp_q[0]);
        if (acc_ready_i) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done_exp = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) cyc();
    check("rst_valid", acc_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_acc", acc_o, 0);
    rst_n = 1'b0;
    cmp_en = 1'b1;
    cyc();

    // single tile
    v = '{1, 2, 3, 4};
    run_tile(1'b1, 1'b1, v, 0, -1);
    check("t1_m0", model_mem[0], 1);
    check("t1_m3", model_mem[3], 4);
    drain(16'hFFFF, 16);

    // two tiles, with psum gaps in the first
    v = '{10, 20, 30, 40};
    run_tile(1'b1, 1'b0, v, 2, -1);
    cyc(); cyc();
    v = '{1, -2, 3, -4};
    run_tile(1'b0, 1'b1, v, 0, -1);
    check("t2_m0", model_mem[0], 11);
    check("t2_m1", model_mem[1], 18);
    check("t2_m2", model_mem[2], 33);
    check("t2_m3", model_mem[3], 36);
    drain(16'hFFFF, 16);

    // positive saturation
    v = '{64'sh7FFF_FFF0, 64'sh7FFF_FFF0, 64'sh7FFF_FFF0, 64'sh7FFF_FFF0};
    run_tile(1'b1, 1'b0, v, 0, -1);
    v = '{32, 32, 32, 32};
    run_tile(1'b0, 1'b1, v, 0, -1);
    check("sat_pos", model_mem[2], 64'sh7FFF_FFFF);
    drain(16'hFFFF, 16);

    // negative saturation: 0x80000010 + -0x20
    v = '{-64'sh7FFF_FFF0, -64'sh7FFF_FFF0, -64'sh7FFF_FFF0, -64'sh7FFF_FFF0};
    run_tile(1'b1, 1'b0, v, 0, -1);
    v = '{-32, -32, -32, -32};
    run_tile(1'b0, 1'b1, v, 0, -1);
    check("sat_neg", model_mem[1], -64'sh8000_0000);
    drain(16'hFFFF, 16);

    // backpressure: ready 0,0,1,0,1,1,1
    v = '{5, 6, 7, 8};
    run_tile(1'b1, 1'b1, v, 0, -1);
    drain(16'h0074, 7);

    // protocol errors: psum in IDLE, then tile_start during ACCUM
    psum_i = 32'sd99; psum_en_i = 1'b1;
    cyc();
    exp_err = 1'b1;
    psum_en_i = 1'b0;
    cyc();
    v = '{-7, 100, 0, 12345};
    run_tile(1'b1, 1'b1, v, 1, 1);
    drain(16'hFFFF, 16);
    check("err_sticky", err_o, 1);

    // reset during DRAIN after two beats
    v = '{7, 8, 9, 10};
    run_tile(1'b1, 1'b1, v, 0, -1);
    acc_ready_i = 1'b1;
    cyc(); cyc();
    acc_ready_i = 1'b0;
    rst_n = 1'b1;
    cyc();
    exp_q.delete();
    exp_err = 1'b0;
    check("rst_mid_valid", acc_valid_o, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_done", done_o, 0);
    rst_n = 1'b0;
    cyc();
    v = '{-1, -2, 300, 4000};
    run_tile(1'b1, 1'b1, v, 0, -1);
    drain(16'h0005, 4);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
